// File: rtl/tile_conf_regs_pkg.sv
// Configuration struct shared between derive_config and the tile-local register block.
package tile_conf_regs_pkg;

    localparam int unsigned CTLIST_LEN = 128;
    localparam int unsigned CT_W       = 16;
    localparam int unsigned CONF_W     = 32;

    typedef struct packed {
        logic [CONF_W-1:0]                numtiles;
        logic [CONF_W-1:0]                cores_per_tile;
        logic [CONF_W-1:0]                gmem_size;
        logic [CONF_W-1:0]                gmem_tile;
        logic [CONF_W-1:0]                lmem_size;
        logic [CONF_W-1:0]                numcts;
        logic                             enable_bootrom;
        logic                             enable_dm;
        logic                             enable_pgas;
        logic                             core_enable_fpu;
        logic                             core_enable_perfcounters;
        logic                             na_enable_mpsimple;
        logic                             na_enable_dma;
        logic                             noc_enable_vchannels;
        logic                             use_debug;
        logic [CTLIST_LEN-1:0][CT_W-1:0]  ctlist;
    } config_t;

endpackage

// File: rtl/tile_conf_regs.sv
// Wishbone register block exposing the system configuration, a 64-bit cycle
// counter with coherent high-word shadow, and a scratch register.
module tile_conf_regs
    import tile_conf_regs_pkg::*;
#(
    parameter config_t     CONFIG   = 'x,
    parameter int unsigned TILEID   = 0,
    parameter int unsigned COREBASE = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] wb_adr_i,
    input  logic [31:0] wb_dat_i,
    input  logic [3:0]  wb_sel_i,
    input  logic        wb_we_i,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    output logic [31:0] wb_dat_o,
    output logic        wb_ack_o,
    output logic        wb_err_o
);

    localparam int unsigned DW     = 32;
    localparam int unsigned CNT_W  = 64;
    localparam int unsigned IDX_W  = 7;
    localparam int unsigned LANES  = DW / 8;

    localparam logic [3:0] REG_TILEID   = 4'h0;
    localparam logic [3:0] REG_NUMTILES = 4'h1;
    localparam logic [3:0] REG_COREBASE = 4'h2;
    localparam logic [3:0] REG_CPT      = 4'h3;
    localparam logic [3:0] REG_GMEM     = 4'h4;
    localparam logic [3:0] REG_GTILE    = 4'h5;
    localparam logic [3:0] REG_LMEM     = 4'h6;
    localparam logic [3:0] REG_NUMCTS   = 4'h7;
    localparam logic [3:0] REG_FLAGS    = 4'h8;
    localparam logic [3:0] REG_CYC_LO   = 4'h9;
    localparam logic [3:0] REG_CYC_HI   = 4'hA;
    localparam logic [3:0] REG_SCRATCH  = 4'hB;

    localparam logic [DW-1:0] FLAGS_VAL = DW'({
        CONFIG.use_debug,
        CONFIG.noc_enable_vchannels,
        CONFIG.na_enable_dma,
        CONFIG.na_enable_mpsimple,
        CONFIG.core_enable_perfcounters,
        CONFIG.core_enable_fpu,
        CONFIG.enable_pgas,
        CONFIG.enable_dm,
        CONFIG.enable_bootrom
    });

    logic [CNT_W-1:0] cycle_cnt;
    logic [DW-1:0]    hi_shadow;
    logic [DW-1:0]    scratch;

    logic             req;
    logic [IDX_W-1:0] ct_idx;
    logic [DW-1:0]    rd_data;
    logic             rd_hit;
    logic             is_scratch;
    logic             is_lo;
    logic             unused_adr;

    assign unused_adr = ^wb_adr_i[1:0];
    assign req        = wb_cyc_i & wb_stb_i & ~wb_ack_o & ~wb_err_o;
    assign ct_idx     = wb_adr_i[8:2];

    // Address decode and read-data mux
    always_comb begin
        rd_data    = '0;
        rd_hit     = 1'b0;
        is_scratch = 1'b0;
        is_lo      = 1'b0;
        if (wb_adr_i[15:9] == 7'd1) begin
            rd_hit = 1'b1;
            if (DW'(ct_idx) < CONFIG.numcts) begin
                rd_data = DW'(CONFIG.ctlist[ct_idx]);
            end
        end else if (wb_adr_i[15:6] == '0) begin
            rd_hit = 1'b1;
            case (wb_adr_i[5:2])
                REG_TILEID:   rd_data = DW'(TILEID);
                REG_NUMTILES: rd_data = CONFIG.numtiles;
                REG_COREBASE: rd_data = DW'(COREBASE);
                REG_CPT:      rd_data = CONFIG.cores_per_tile;
                REG_GMEM:     rd_data = CONFIG.gmem_size;
                REG_GTILE:    rd_data = CONFIG.gmem_tile;
                REG_LMEM:     rd_data = CONFIG.lmem_size;
                REG_NUMCTS:   rd_data = CONFIG.numcts;
                REG_FLAGS:    rd_data = FLAGS_VAL;
                REG_CYC_LO: begin
                    rd_data = cycle_cnt[DW-1:0];
                    is_lo   = 1'b1;
                end
                REG_CYC_HI:   rd_data = hi_shadow;
                REG_SCRATCH: begin
                    rd_data    = scratch;
                    is_scratch = 1'b1;
                end
                default:      rd_hit = 1'b0;
            endcase
        end
    end

    // Counter, side effects and single-cycle response
    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_cnt <= '0;
            hi_shadow <= '0;
            scratch   <= '0;
            wb_ack_o  <= 1'b0;
            wb_err_o  <= 1'b0;
            wb_dat_o  <= '0;
        end else begin
            cycle_cnt <= cycle_cnt + CNT_W'(1);
            wb_ack_o  <= 1'b0;
            wb_err_o  <= 1'b0;
            wb_dat_o  <= '0;
            if (req) begin
                if (!rd_hit || (wb_we_i && !is_scratch)) begin
                    wb_err_o <= 1'b1;
                end else begin
                    wb_ack_o <= 1'b1;
                    if (wb_we_i) begin
                        for (int k = 0; k < LANES; k++) begin
                            if (wb_sel_i[k]) begin
                                scratch[8*k +: 8] <= wb_dat_i[8*k +: 8];
                            end
                        end
                    end else begin
                        wb_dat_o <= rd_data;
                        if (is_lo) begin
                            hi_shadow <= cycle_cnt[CNT_W-1:DW];
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_tile_conf_regs.sv
// Directed plus randomized bench for tile_conf_regs against a register-map level model.
module tb_tile_conf_regs;
    import tile_conf_regs_pkg::*;

    localparam int unsigned TB_TILEID   = 3;
    localparam int unsigned TB_COREBASE = 6;
    localparam logic [31:0] TB_NUMTILES = 32'd4;
    localparam logic [31:0] TB_CPT      = 32'd2;
    localparam logic [31:0] TB_GMEM     = 32'h1000_0000;
    localparam logic [31:0] TB_GTILE    = 32'h0100_0000;
    localparam logic [31:0] TB_LMEM     = 32'h0001_0000;
    localparam logic [31:0] TB_NUMCTS   = 32'd2;
    localparam logic [15:0] TB_CT0      = 16'h0002;
    localparam logic [15:0] TB_CT1      = 16'h0005;
    // bootrom (bit 0), dm (bit 1), debug (bit 8)
    localparam logic [31:0] TB_FLAGS    = 32'h0000_0103;

    function automatic config_t mk_cfg();
        config_t c;
        c                = '0;
        c.numtiles       = TB_NUMTILES;
        c.cores_per_tile = TB_CPT;
        c.gmem_size      = TB_GMEM;
        c.gmem_tile      = TB_GTILE;
        c.lmem_size      = TB_LMEM;
        c.numcts         = TB_NUMCTS;
        c.enable_bootrom = 1'b1;
        c.enable_dm      = 1'b1;
        c.use_debug      = 1'b1;
        c.ctlist[0]      = TB_CT0;
        c.ctlist[1]      = TB_CT1;
        return c;
    endfunction

    localparam config_t TB_CFG = mk_cfg();

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] wb_adr_i = '0;
    logic [31:0] wb_dat_i = '0;
    logic [3:0]  wb_sel_i = '0;
    logic        wb_we_i  = 1'b0;
    logic        wb_cyc_i = 1'b0;
    logic        wb_stb_i = 1'b0;
    logic [31:0] wb_dat_o;
    logic        wb_ack_o;
    logic        wb_err_o;

    tile_conf_regs #(
        .CONFIG   (TB_CFG),
        .TILEID   (TB_TILEID),
        .COREBASE (TB_COREBASE)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .wb_adr_i (wb_adr_i),
        .wb_dat_i (wb_dat_i),
        .wb_sel_i (wb_sel_i),
        .wb_we_i  (wb_we_i),
        .wb_cyc_i (wb_cyc_i),
        .wb_stb_i (wb_stb_i),
        .wb_dat_o (wb_dat_o),
        .wb_ack_o (wb_ack_o),
        .wb_err_o (wb_err_o)
    );

    always #5 clk = ~clk;

    int n_edge = 0;
    always @(posedge clk) n_edge <= n_edge + 1;

    int          passed = 0;
    int          fails  = 0;
    int          total  = 0;
    int          base_k = 0;
    logic [63:0] base_val = '0;
    logic [31:0] m_scratch = '0;
    logic [31:0] m_shadow  = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Counter value during the cycle whose closing edge is edge k+1
    function automatic logic [63:0] cnt_at(input int k);
        return base_val + 64'(k - base_k);
    endfunction

    // Register-map model: response plus state side effects
    task automatic model(input logic [15:0] adr, input logic we, input logic [31:0] wd,
                         input logic [3:0] sel, input logic [63:0] cnt,
                         output logic ea, output logic ee, output logic [31:0] ed);
        int a;
        int idx;
        a  = int'(adr) & 32'hFFFC;
        ea = 1'b0;
        ee = 1'b0;
        ed = '0;
        if (a >= 32'h200 && a <= 32'h3FC) begin
            idx = (a - 32'h200) / 4;
            if (we) ee = 1'b1;
            else begin
                ea = 1'b1;
                if (idx < int'(TB_NUMCTS)) ed = (idx == 0) ? 32'(TB_CT0) : 32'(TB_CT1);
            end
        end else begin
            case (a)
                32'h00:  ed = 32'(TB_TILEID);
                32'h04:  ed = TB_NUMTILES;
                32'h08:  ed = 32'(TB_COREBASE);
                32'h0C:  ed = TB_CPT;
                32'h10:  ed = TB_GMEM;
                32'h14:  ed = TB_GTILE;
                32'h18:  ed = TB_LMEM;
                32'h1C:  ed = TB_NUMCTS;
                32'h20:  ed = TB_FLAGS;
                32'h24:  ed = cnt[31:0];
                32'h28:  ed = m_shadow;
                32'h2C:  ed = m_scratch;
                default: ee = 1'b1;
            endcase
            if (we && a != 32'h2C) ee = 1'b1;
            if (!ee) begin
                ea = 1'b1;
                if (we) begin
                    for (int k = 0; k < 4; k++)
                        if (sel[k]) m_scratch[8*k +: 8] = wd[8*k +: 8];
                end else if (a == 32'h24) begin
                    m_shadow = cnt[63:32];
                end
            end
        end
        if (ee) ed = '0;
    endtask

    // One transfer: request in cycle N, sample N+1, confirm quiet in N+2
    task automatic xfer(input string tag, input logic [15:0] adr, input logic we,
                        input logic [31:0] wd, input logic [3:0] sel,
                        output logic a, output logic e, output logic [31:0] d, output int k);
        @(negedge clk);
        wb_adr_i = adr; wb_we_i = we; wb_dat_i = wd; wb_sel_i = sel;
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
        k = n_edge;
        @(posedge clk); #1;
        a = wb_ack_o; e = wb_err_o; d = wb_dat_o;
        @(negedge clk);
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
        @(posedge clk); #1;
        chk({tag, "_n2"}, {30'd0, wb_ack_o, wb_err_o}, 32'd0);
    endtask

    task automatic run(input string tag, input logic [15:0] adr, input logic we,
                       input logic [31:0] wd, input logic [3:0] sel, output logic [31:0] d);
        logic a, e, ea, ee;
        logic [31:0] ed;
        int k;
        xfer(tag, adr, we, wd, sel, a, e, d, k);
        model(adr, we, wd, sel, cnt_at(k), ea, ee, ed);
        chk({tag, "_ack"}, 32'(a), 32'(ea));
        chk({tag, "_err"}, 32'(e), 32'(ee));
        if (!we || ee) chk({tag, "_dat"}, d, ed);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        base_k = n_edge; base_val = '0;
        m_scratch = '0; m_shadow = '0;
    endtask

    initial begin
        logic [31:0] d;
        logic [15:0] radr;
        int          acks;
        int          mode;

        do_reset();
        chk("rst_ack", 32'(wb_ack_o), 32'd0);
        chk("rst_err", 32'(wb_err_o), 32'd0);
        chk("rst_dat", wb_dat_o, 32'd0);

        run("tileid",   16'h000, 1'b0, '0, 4'h0, d);
        run("corebase", 16'h008, 1'b0, '0, 4'h0, d);

        run("ct0",      16'h200, 1'b0, '0, 4'h0, d);
        run("ct1",      16'h204, 1'b0, '0, 4'h0, d);
        run("ct2_zero", 16'h208, 1'b0, '0, 4'h0, d);
        run("unmapped", 16'h400, 1'b0, '0, 4'h0, d);

        run("scr_w0",   16'h02C, 1'b1, 32'hDEADBEEF, 4'hF, d);
        run("scr_w1",   16'h02C, 1'b1, 32'h00001200, 4'h2, d);
        run("scr_r",    16'h02C, 1'b0, '0, 4'h0, d);
        chk("scr_val",  d, 32'hDEAD12EF);
        run("scr_sel0", 16'h02C, 1'b1, 32'h12345678, 4'h0, d);
        run("scr_r2",   16'h02C, 1'b0, '0, 4'h0, d);
        run("ro_write", 16'h000, 1'b1, 32'h5, 4'hF, d);
        run("ro_after", 16'h000, 1'b0, '0, 4'h0, d);
        chk("tileid_kept", d, 32'd3);
        run("ct_write", 16'h204, 1'b1, 32'h7, 4'hF, d);

        // Counter coherence across the low-word carry
        @(posedge clk); #1;
        force dut.cycle_cnt = 64'h0000_0000_FFFF_FFFE;
        #1;
        release dut.cycle_cnt;
        base_k = n_edge; base_val = 64'h0000_0000_FFFF_FFFE;
        run("lo1", 16'h024, 1'b0, '0, 4'h0, d);
        chk("lo1_abs", d, 32'hFFFF_FFFE);
        run("hi1", 16'h028, 1'b0, '0, 4'h0, d);
        chk("hi1_abs", d, 32'h0);
        run("lo2", 16'h024, 1'b0, '0, 4'h0, d);
        chk("lo2_range", 32'(d <= 32'd3), 32'd1);
        run("hi2", 16'h028, 1'b0, '0, 4'h0, d);
        chk("hi2_abs", d, 32'h1);

        // Strobe held high: one acceptance per two cycles
        @(negedge clk);
        wb_adr_i = 16'h020; wb_we_i = 1'b0; wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
        acks = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            chk("b2b_ack", 32'(wb_ack_o), 32'((i % 2) == 0));
            chk("b2b_err", 32'(wb_err_o), 32'd0);
            if (wb_ack_o) begin
                acks++;
                chk("b2b_dat", wb_dat_o, TB_FLAGS);
            end
        end
        @(negedge clk);
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
        chk("b2b_count", 32'(acks), 32'd3);

        // Reset coinciding with a request drops it
        @(negedge clk);
        wb_adr_i = 16'h024; wb_we_i = 1'b0; wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rstreq_ack", 32'(wb_ack_o), 32'd0);
        chk("rstreq_err", 32'(wb_err_o), 32'd0);
        chk("rstreq_dat", wb_dat_o, 32'd0);
        @(negedge clk);
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0; rst = 1'b0;
        base_k = n_edge; base_val = '0;
        m_scratch = '0; m_shadow = '0;
        @(posedge clk); #1;
        chk("rstreq_quiet", {30'd0, wb_ack_o, wb_err_o}, 32'd0);
        run("post_rst_lo", 16'h024, 1'b0, '0, 4'h0, d);
        chk("post_rst_range", 32'(d <= 32'd2), 32'd1);
        run("post_rst_scr", 16'h02C, 1'b0, '0, 4'h0, d);

        // Randomized traffic against the model
        for (int i = 0; i < 40; i++) begin
            mode = int'($urandom_range(0, 3));
            case (mode)
                0:       radr = 16'(4 * $urandom_range(0, 12));
                1:       radr = 16'(32'h200 + 4 * $urandom_range(0, 4));
                2:       radr = 16'($urandom());
                default: radr = 16'h024;
            endcase
            radr = radr | 16'($urandom_range(0, 3));
            if (mode == 3) begin
                run("rnd_lo", radr, 1'b0, '0, 4'h0, d);
                run("rnd_hi", 16'h028, 1'b0, '0, 4'h0, d);
            end else if (mode == 0 && $urandom_range(0, 1) == 1) begin
                run("rnd_scr", 16'h02C, 1'b1, $urandom(), 4'($urandom_range(0, 15)), d);
            end else begin
                run("rnd", radr, ($urandom_range(0, 3) == 0), $urandom(),
                    4'($urandom_range(0, 15)), d);
            end
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end
        run("rnd_scr_final", 16'h02C, 1'b0, '0, 4'h0, d);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
